// File: rtl/lemming_pkg.sv
// Shared types and helpers for the lemming track model: walk-direction decode and position width.
package lemming_pkg;

  typedef enum logic [1:0] {DIR_IDLE, DIR_LEFT, DIR_RIGHT, DIR_BAD} lem_dir_t;

  // One-hot walk inputs give a direction; both-low and both-high are illegal on a tick.
  function automatic lem_dir_t decode_dir(input logic walk_left, input logic walk_right);
    lem_dir_t dir;
    case ({walk_left, walk_right})
      2'b10:   dir = DIR_LEFT;
      2'b01:   dir = DIR_RIGHT;
      2'b11:   dir = DIR_BAD;
      default: dir = DIR_IDLE;
    endcase
    return dir;
  endfunction

  function automatic int unsigned pos_w(input int unsigned track_len);
    return (track_len > 2) ? int'($clog2(track_len)) : 1;
  endfunction

endpackage

// File: rtl/lemming_step_prescaler.sv
// Movement prescaler: tick is high in the last cycle of every STEP_DIV-cycle period.
module lemming_step_prescaler #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clk,
  input  logic areset,
  output logic tick
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // With STEP_DIV=1 the counter is pinned at 0 and tick is permanently high.
  always_comb begin
    tick    = (count_q == CNT_W'(STEP_DIV - 1));
    count_d = tick ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/lemming_track_model.sv
// World model for the lemming walker: bounded 1-D track with wall-bump pulses.
// Optional bump_count port enabled by defining LEMMING_BUMP_CNT_EN.
module lemming_track_model
  import lemming_pkg::*;
#(
  parameter int unsigned TRACK_LEN = 16,
  parameter int unsigned START_POS = 0,
  parameter int unsigned STEP_DIV  = 4
`ifdef LEMMING_BUMP_CNT_EN
  ,
  parameter int unsigned CNT_W     = 8
`endif
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          walk_left,
  input  logic                          walk_right,
  output logic [pos_w(TRACK_LEN)-1:0]   pos,
  output logic                          bump_left,
  output logic                          bump_right,
  output logic                          dir_err
`ifdef LEMMING_BUMP_CNT_EN
  ,
  output logic [CNT_W-1:0]              bump_count
`endif
);

  localparam int unsigned POS_W = pos_w(TRACK_LEN);

  logic             tick;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             bump_left_q, bump_left_d;
  logic             bump_right_q, bump_right_d;
  logic             dir_err_q, dir_err_d;

  lemming_step_prescaler #(
    .STEP_DIV (STEP_DIV)
  ) u_prescaler (
    .clk    (clk),
    .areset (areset),
    .tick   (tick)
  );

  // Walls saturate the position and raise a single-cycle bump instead of moving.
  always_comb begin
    pos_d        = pos_q;
    bump_left_d  = 1'b0;
    bump_right_d = 1'b0;
    dir_err_d    = dir_err_q;
    if (tick) begin
      case (decode_dir(walk_left, walk_right))
        DIR_LEFT: begin
          if (pos_q == '0) bump_left_d = 1'b1;
          else             pos_d       = pos_q - POS_W'(1);
        end
        DIR_RIGHT: begin
          if (pos_q == POS_W'(TRACK_LEN - 1)) bump_right_d = 1'b1;
          else                                pos_d        = pos_q + POS_W'(1);
        end
        default: dir_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pos_q        <= POS_W'(START_POS);
      bump_left_q  <= 1'b0;
      bump_right_q <= 1'b0;
      dir_err_q    <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      bump_left_q  <= bump_left_d;
      bump_right_q <= bump_right_d;
      dir_err_q    <= dir_err_d;
    end
  end

  assign pos        = pos_q;
  assign bump_left  = bump_left_q;
  assign bump_right = bump_right_q;
  assign dir_err    = dir_err_q;

`ifdef LEMMING_BUMP_CNT_EN
  logic [CNT_W-1:0] bump_count_q, bump_count_d;

  // Counts cycles with a visible bump, saturating at all-ones.
  always_comb begin
    bump_count_d = bump_count_q;
    if ((bump_left_q | bump_right_q) && (bump_count_q != '1))
      bump_count_d = bump_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) bump_count_q <= '0;
    else        bump_count_q <= bump_count_d;
  end

  assign bump_count = bump_count_q;
`endif

endmodule

// File: tb/tb_lemming_track_model.sv
// Directed bench for lemming_track_model (TRACK_LEN=4, START_POS=0, STEP_DIV=2).
module tb_lemming_track_model;

  logic       clk;
  logic       areset;
  logic       walk_left;
  logic       walk_right;
  logic [1:0] pos;
  logic       bump_left;
  logic       bump_right;
  logic       dir_err;
  int         checks;
  int         failures;

`ifdef LEMMING_BUMP_CNT_EN
  logic [7:0] bump_count;
  logic [1:0] c_pos;
  logic       c_bump_left;
  logic       c_bump_right;
  logic       c_dir_err;
  logic [1:0] c_bump_count;
`endif

  lemming_track_model #(
    .TRACK_LEN (4),
    .START_POS (0),
    .STEP_DIV  (2)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .pos        (pos),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .dir_err    (dir_err)
`ifdef LEMMING_BUMP_CNT_EN
    ,
    .bump_count (bump_count)
`endif
  );

`ifdef LEMMING_BUMP_CNT_EN
  lemming_track_model #(
    .TRACK_LEN (4),
    .START_POS (0),
    .STEP_DIV  (1),
    .CNT_W     (2)
  ) dut_cnt (
    .clk        (clk),
    .areset     (areset),
    .walk_left  (1'b1),
    .walk_right (1'b0),
    .pos        (c_pos),
    .bump_left  (c_bump_left),
    .bump_right (c_bump_right),
    .dir_err    (c_dir_err),
    .bump_count (c_bump_count)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_pos [10] = '{1, 2, 3, 3, 2, 1, 0, 0, 1, 2};

  initial begin
    clk        = 1'b0;
    checks     = 0;
    failures   = 0;
    areset     = 1'b1;
    walk_left  = 1'b1;
    walk_right = 1'b0;
    #12;
    check("rst_pos", int'(pos), 0);
    check("rst_bump_l", int'(bump_left), 0);
    check("rst_bump_r", int'(bump_right), 0);
    check("rst_dir_err", int'(dir_err), 0);
    step(1);
    areset = 1'b0;

    // Walking left at pos 0: bump_left pulses after every second edge.
    step(1);
    check("left_e1_bump", int'(bump_left), 0);
    step(1);
    check("left_e2_bump", int'(bump_left), 1);
    check("left_e2_pos", int'(pos), 0);
    check("left_e2_bump_r", int'(bump_right), 0);
    step(1);
    check("left_e3_bump", int'(bump_left), 0);
    step(1);
    check("left_e4_bump", int'(bump_left), 1);
    check("left_e4_pos", int'(pos), 0);

    // Walk right to the far wall.
    walk_left  = 1'b0;
    walk_right = 1'b1;
    step(1);
    check("right_e5_bump_l", int'(bump_left), 0);
    check("right_e5_pos", int'(pos), 0);
    step(1);
    check("right_pos1", int'(pos), 1);
    step(2);
    check("right_pos2", int'(pos), 2);
    step(2);
    check("right_pos3", int'(pos), 3);
    check("right_pos3_bump", int'(bump_right), 0);
    step(2);
    check("right_wall_pos", int'(pos), 3);
    check("right_wall_bump", int'(bump_right), 1);
    check("right_wall_bump_l", int'(bump_left), 0);
    step(1);
    check("right_wall_drop", int'(bump_right), 0);

    // Both walk inputs high on a tick.
    walk_left = 1'b1;
    step(1);
    check("bad_pos", int'(pos), 3);
    check("bad_bump_r", int'(bump_right), 0);
    check("bad_bump_l", int'(bump_left), 0);
    check("bad_dir_err", int'(dir_err), 1);
    walk_right = 1'b0;
    step(2);
    check("after_bad_pos", int'(pos), 2);
    check("after_bad_sticky", int'(dir_err), 1);

    // Asynchronous reset between ticks, then first tick two edges after release.
    step(1);
    check("pre_rst_pos", int'(pos), 2);
    areset = 1'b1;
    #1;
    check("async_rst_pos", int'(pos), 0);
    check("async_rst_dir_err", int'(dir_err), 0);
    check("async_rst_bumps", int'(bump_left | bump_right), 0);
    walk_left  = 1'b0;
    walk_right = 1'b1;
    #1;
    areset = 1'b0;
    step(1);
    check("post_rst_e1_pos", int'(pos), 0);
    step(1);
    check("post_rst_e2_pos", int'(pos), 1);

    // Closed loop with a walker that reverses one edge after each bump.
    step(1);
    areset = 1'b1;
    #1;
    areset = 1'b0;
    walk_left  = 1'b0;
    walk_right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("loop_idle_bumps", int'(bump_left | bump_right), 0);
      step(1);
      check($sformatf("loop_pos%0d", i), int'(pos), exp_pos[i]);
      check($sformatf("loop_bump_r%0d", i), int'(bump_right), (i == 3) ? 1 : 0);
      check($sformatf("loop_bump_l%0d", i), int'(bump_left), (i == 7) ? 1 : 0);
      if (bump_left) begin
        walk_left  = 1'b0;
        walk_right = 1'b1;
      end else if (bump_right) begin
        walk_left  = 1'b1;
        walk_right = 1'b0;
      end
    end
    check("loop_dir_err", int'(dir_err), 0);

`ifdef LEMMING_BUMP_CNT_EN
    // Bump counter saturation with STEP_DIV=1 against the left wall.
    areset = 1'b1;
    #1;
    check("cnt_rst", int'(c_bump_count), 0);
    areset = 1'b0;
    step(1);
    check("cnt_e1_bump", int'(c_bump_left), 1);
    check("cnt_e1", int'(c_bump_count), 0);
    step(1);
    check("cnt_e2", int'(c_bump_count), 1);
    step(1);
    check("cnt_e3", int'(c_bump_count), 2);
    step(1);
    check("cnt_e4", int'(c_bump_count), 3);
    step(1);
    check("cnt_sat", int'(c_bump_count), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
